id_ex_reg: RTL and testbench

ID/EX pipeline register of the 5-stage MIPS core. It latches the decoded control bundle and the operands produced in ID, and presents them to EX. It also contains the load-use hazard detector: when a hazard is found, it stalls PC and IF/ID and inserts one bubble. It supports debug halt (freeze), branch/jump flush, and a saturating bubble counter for the debug unit.

---
 rtl/id_ex_reg.sv | 206 ++++++++++++++++++++
 tb/tb_id_ex_reg.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
//
// ID/EX pipeline register of the 5-stage MIPS core, with the load-use hazard
// detector and a saturating bubble counter for the debug unit.
//
// The register captures the decoded control bundle and the ID operands, then
// presents them to EX one cycle later. When the instruction now in EX is a
// load whose destination feeds the instruction in ID, o_load_use_stall rises
// combinationally. Upstream logic then holds PC and IF/ID, and this stage
// loads a bubble on the next edge.
//
// Edge priority: halt (hold everything) > flush (bubble) > load-use (bubble)
// > normal load. Reset is asynchronous and overrides halt.
//
// Ports
//   i_clk, i_reset          clock (rising edge), async active-high reset
//   i_halt                  debug freeze: every register holds
//   i_flush                 control transfer taken in ID: squash incoming
//   i_valid                 IF/ID holds a real instruction
//   i_uses_rs, i_uses_rt    incoming instruction reads rs / rt
//   i_reg_dst .. i_reg_write, i_alu_op, i_branch_type
//                           control bundle from the decoder
//   i_opcode, i_funct       raw fields for EX ALU control and MEM access width
//   i_rs, i_rt, i_rd        register specifiers (rd = 31 already for JAL/JALR)
//   i_pc_plus4, i_rs_data, i_rt_data, i_imm
//                           operands
//   o_*                     registered copies presented to EX
//   o_write_reg             registered destination (i_reg_dst ? i_rd : i_rt)
//   o_load_use_stall        combinational: hold PC and IF/ID this cycle
//   o_bubble_count          saturating count of bubbles inserted since reset
// -----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic               i_uses_rs,
    input  logic               i_uses_rt,
    input  logic               i_reg_dst,
    input  logic               i_alu_src,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic               i_mem_to_reg,
    input  logic               i_reg_write,
    input  logic [2:0]         i_alu_op,
    input  logic [2:0]         i_branch_type,
    input  logic [5:0]         i_opcode,
    input  logic [5:0]         i_funct,
    input  logic [4:0]         i_rs,
    input  logic [4:0]         i_rt,
    input  logic [4:0]         i_rd,
    input  logic [DATA_W-1:0]  i_pc_plus4,
    input  logic [DATA_W-1:0]  i_rs_data,
    input  logic [DATA_W-1:0]  i_rt_data,
    input  logic [DATA_W-1:0]  i_imm,
    output logic               o_valid,
    output logic               o_reg_dst,
    output logic               o_alu_src,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_mem_to_reg,
    output logic               o_reg_write,
    output logic [2:0]         o_alu_op,
    output logic [2:0]         o_branch_type,
    output logic [5:0]         o_opcode,
    output logic [5:0]         o_funct,
    output logic [4:0]         o_rs,
    output logic [4:0]         o_rt,
    output logic [4:0]         o_write_reg,
    output logic [DATA_W-1:0]  o_pc_plus4,
    output logic [DATA_W-1:0]  o_rs_data,
    output logic [DATA_W-1:0]  o_rt_data,
    output logic [DATA_W-1:0]  o_imm,
    output logic               o_load_use_stall,
    output logic [COUNT_W-1:0] o_bubble_count
);

    // Everything EX sees, held as one record. An all-zero record is a
    // bubble: invalid, no memory access, no register write, no branch.
    typedef struct packed {
        logic              valid;
        logic              reg_dst;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic [2:0]        alu_op;
        logic [2:0]        branch_type;
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        write_reg;
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } ex_stage_t;

    ex_stage_t          r_stage;
    ex_stage_t          w_next_stage;
    logic [COUNT_W-1:0] r_bubble_count;
    logic               w_rs_hit;
    logic               w_rt_hit;
    logic               w_load_use;
    logic               w_insert_bubble;
    logic               w_count_saturated;

    // ------------------------------------------------------------------
    // Load-use hazard: the load in EX writes a register that the
    // instruction in ID actually reads. $0 is never a real dependency.
    // Deliberately not gated by halt or flush; upstream resolves priority.
    // ------------------------------------------------------------------
    assign w_rs_hit   = i_uses_rs && (r_stage.write_reg == i_rs);
    assign w_rt_hit   = i_uses_rt && (r_stage.write_reg == i_rt);
    assign w_load_use = r_stage.valid && r_stage.mem_read &&
                        (r_stage.write_reg != 5'd0) && i_valid &&
                        (w_rs_hit || w_rt_hit);

    // Flush and hazard collapse into a single bubble (and a single count).
    assign w_insert_bubble   = i_flush || w_load_use;
    assign w_count_saturated = &r_bubble_count;

    // ------------------------------------------------------------------
    // Next stage contents: either the incoming instruction or a bubble.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: the whole record is defaulted to the bubble value before any
        // condition, so every field is assigned on every path and no latch
        // can be inferred.
        w_next_stage = '0;
        if (!w_insert_bubble) begin
            w_next_stage.valid       = i_valid;
            w_next_stage.reg_dst     = i_reg_dst;
            w_next_stage.alu_src     = i_alu_src;
            w_next_stage.mem_read    = i_mem_read;
            w_next_stage.mem_write   = i_mem_write;
            w_next_stage.mem_to_reg  = i_mem_to_reg;
            w_next_stage.reg_write   = i_reg_write;
            w_next_stage.alu_op      = i_alu_op;
            w_next_stage.branch_type = i_branch_type;
            w_next_stage.opcode      = i_opcode;
            w_next_stage.funct       = i_funct;
            w_next_stage.rs          = i_rs;
            w_next_stage.rt          = i_rt;
            // Destination is resolved here so EX/MEM/WB and the hazard
            // check above only ever compare one 5-bit field.
            w_next_stage.write_reg   = i_reg_dst ? i_rd : i_rt;
            w_next_stage.pc_plus4    = i_pc_plus4;
            w_next_stage.rs_data     = i_rs_data;
            w_next_stage.rt_data     = i_rt_data;
            w_next_stage.imm         = i_imm;
        end
    end

    // ------------------------------------------------------------------
    // Stage register and bubble counter.
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments for all state, so every register
    // samples values from before the edge regardless of statement order.
    // NOTE: the datapath fields are reset too, not just the valid bit; EX
    // and the debug unit observe them directly and must see a deterministic
    // bubble straight out of reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stage        <= '0;
            r_bubble_count <= '0;
        end else if (!i_halt) begin
            r_stage <= w_next_stage;
            if (w_insert_bubble && !w_count_saturated) begin
                r_bubble_count <= r_bubble_count + COUNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign o_valid          = r_stage.valid;
    assign o_reg_dst        = r_stage.reg_dst;
    assign o_alu_src        = r_stage.alu_src;
    assign o_mem_read       = r_stage.mem_read;
    assign o_mem_write      = r_stage.mem_write;
    assign o_mem_to_reg     = r_stage.mem_to_reg;
    assign o_reg_write      = r_stage.reg_write;
    assign o_alu_op         = r_stage.alu_op;
    assign o_branch_type    = r_stage.branch_type;
    assign o_opcode         = r_stage.opcode;
    assign o_funct          = r_stage.funct;
    assign o_rs             = r_stage.rs;
    assign o_rt             = r_stage.rt;
    assign o_write_reg      = r_stage.write_reg;
    assign o_pc_plus4       = r_stage.pc_plus4;
    assign o_rs_data        = r_stage.rs_data;
    assign o_rt_data        = r_stage.rt_data;
    assign o_imm            = r_stage.imm;
    assign o_load_use_stall = w_load_use;
    assign o_bubble_count   = r_bubble_count;

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
//
// Scoreboard bench for id_ex_reg (COUNT_W = 4 so saturation is reachable).
// The driver applies one instruction per cycle, checks the combinational
// stall against a reference model, advances the model and queues the
// expected EX view. A separate monitor pops one entry after every rising
// edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

    localparam int DATA_W    = 32;
    localparam int COUNT_W   = 4;
    localparam int COUNT_MAX = 15;

    typedef struct packed {
        logic        valid;
        logic        reg_dst;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic [2:0]  alu_op;
        logic [2:0]  branch_type;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  write_reg;
        logic [31:0] pc_plus4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
    } stage_t;

    typedef struct {
        stage_t     stage;
        logic [3:0] count;
    } exp_t;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b0;
    logic               i_halt, i_flush, i_valid, i_uses_rs, i_uses_rt;
    logic               i_reg_dst, i_alu_src, i_mem_read, i_mem_write;
    logic               i_mem_to_reg, i_reg_write;
    logic [2:0]         i_alu_op, i_branch_type;
    logic [5:0]         i_opcode, i_funct;
    logic [4:0]         i_rs, i_rt, i_rd;
    logic [DATA_W-1:0]  i_pc_plus4, i_rs_data, i_rt_data, i_imm;
    logic               o_valid, o_reg_dst, o_alu_src, o_mem_read, o_mem_write;
    logic               o_mem_to_reg, o_reg_write;
    logic [2:0]         o_alu_op, o_branch_type;
    logic [5:0]         o_opcode, o_funct;
    logic [4:0]         o_rs, o_rt, o_write_reg;
    logic [DATA_W-1:0]  o_pc_plus4, o_rs_data, o_rt_data, o_imm;
    logic               o_load_use_stall;
    logic [COUNT_W-1:0] o_bubble_count;

    int     checks = 0;
    int     errors = 0;
    exp_t   sb_q[$];
    stage_t model_stage;
    int     model_count;
    stage_t dut_stage;

    always #5 i_clk = ~i_clk;

    id_ex_reg #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt), .i_flush(i_flush),
        .i_valid(i_valid), .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
        .i_reg_dst(i_reg_dst), .i_alu_src(i_alu_src), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg),
        .i_reg_write(i_reg_write), .i_alu_op(i_alu_op),
        .i_branch_type(i_branch_type), .i_opcode(i_opcode), .i_funct(i_funct),
        .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_pc_plus4(i_pc_plus4),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .o_valid(o_valid), .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
        .o_alu_op(o_alu_op), .o_branch_type(o_branch_type),
        .o_opcode(o_opcode), .o_funct(o_funct), .o_rs(o_rs), .o_rt(o_rt),
        .o_write_reg(o_write_reg), .o_pc_plus4(o_pc_plus4),
        .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
        .o_load_use_stall(o_load_use_stall), .o_bubble_count(o_bubble_count)
    );

    always_comb begin
        dut_stage = {o_valid, o_reg_dst, o_alu_src, o_mem_read, o_mem_write,
                     o_mem_to_reg, o_reg_write, o_alu_op, o_branch_type,
                     o_opcode, o_funct, o_rs, o_rt, o_write_reg, o_pc_plus4,
                     o_rs_data, o_rt_data, o_imm};
    end

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A dependency exists when EX holds a valid load to a nonzero register
    // that ID really reads.
    function automatic bit model_hazard();
        bit reads;
        reads = (i_uses_rs && i_rs == model_stage.write_reg) ||
                (i_uses_rt && i_rt == model_stage.write_reg);
        return model_stage.valid && model_stage.mem_read &&
               model_stage.write_reg != 0 && i_valid && reads;
    endfunction

    task automatic model_edge(input bit hazard);
        if (i_halt) return;
        if (i_flush || hazard) begin
            model_stage = '0;
            model_count = (model_count >= COUNT_MAX) ? COUNT_MAX : model_count + 1;
        end else begin
            model_stage = '0;
            model_stage.valid       = i_valid;
            model_stage.reg_dst     = i_reg_dst;
            model_stage.alu_src     = i_alu_src;
            model_stage.mem_read    = i_mem_read;
            model_stage.mem_write   = i_mem_write;
            model_stage.mem_to_reg  = i_mem_to_reg;
            model_stage.reg_write   = i_reg_write;
            model_stage.alu_op      = i_alu_op;
            model_stage.branch_type = i_branch_type;
            model_stage.opcode      = i_opcode;
            model_stage.funct       = i_funct;
            model_stage.rs          = i_rs;
            model_stage.rt          = i_rt;
            model_stage.write_reg   = i_reg_dst ? i_rd : i_rt;
            model_stage.pc_plus4    = i_pc_plus4;
            model_stage.rs_data     = i_rs_data;
            model_stage.rt_data     = i_rt_data;
            model_stage.imm         = i_imm;
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic begin_cycle();
        @(negedge i_clk);
        i_halt = 0; i_flush = 0; i_valid = 0; i_uses_rs = 0; i_uses_rt = 0;
        i_reg_dst = 0; i_alu_src = 0; i_mem_read = 0; i_mem_write = 0;
        i_mem_to_reg = 0; i_reg_write = 0; i_alu_op = 0; i_branch_type = 0;
        i_opcode = 6'($urandom); i_funct = 6'($urandom);
        i_rs = 0; i_rt = 0; i_rd = 0;
        i_pc_plus4 = $urandom; i_rs_data = $urandom;
        i_rt_data = $urandom;  i_imm = $urandom;
    endtask

    task automatic end_cycle();
        exp_t e;
        bit   hz;
        #1;
        hz = model_hazard();
        check("load_use_stall", 256'(o_load_use_stall), 256'(hz));
        model_edge(hz);
        e.stage = model_stage;
        e.count = 4'(model_count);
        sb_q.push_back(e);
        @(posedge i_clk);
    endtask

    task automatic set_random();
        i_halt       = ($urandom_range(0, 9) == 0);
        i_flush      = ($urandom_range(0, 9) == 0);
        i_valid      = ($urandom_range(0, 3) != 0);
        i_uses_rs    = 1'($urandom);
        i_uses_rt    = 1'($urandom);
        i_reg_dst    = 1'($urandom);
        i_alu_src    = 1'($urandom);
        i_mem_read   = 1'($urandom);
        i_mem_write  = 1'($urandom);
        i_mem_to_reg = 1'($urandom);
        i_reg_write  = 1'($urandom);
        i_alu_op     = 3'($urandom);
        i_branch_type = 3'($urandom);
        // Small register range so dependencies (and $0) occur often.
        i_rs = 5'($urandom_range(0, 7));
        i_rt = 5'($urandom_range(0, 7));
        i_rd = 5'($urandom_range(0, 7));
    endtask

    task automatic load_instr(input bit is_load, input logic [4:0] dst);
        begin_cycle();
        i_valid = 1; i_reg_write = 1; i_alu_src = is_load;
        i_mem_read = is_load; i_mem_to_reg = is_load;
        i_reg_dst = 0; i_rt = dst; i_rs = 5'd29; i_uses_rs = 1;
        end_cycle();
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        #2 i_reset = 1;
        #1;
        check("reset_stage", 256'(dut_stage), 256'(0));
        check("reset_count", 256'(o_bubble_count), 256'(0));
        model_stage = '0;
        model_count = 0;
        @(posedge i_clk);
        #3 i_reset = 0;
    endtask

    // ---------------- monitor ----------------
    always @(posedge i_clk) begin
        exp_t e;
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("ex_stage", 256'(dut_stage), 256'(e.stage));
            check("bubble_count", 256'(o_bubble_count), 256'(e.count));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        begin_cycle();
        model_stage = '0;
        model_count = 0;
        do_reset();

        // Load-use: LW $5 then ADD reading $5 -> bubble, then ADD proceeds.
        load_instr(1'b1, 5'd5);
        for (int k = 0; k < 2; k++) begin
            begin_cycle();
            i_valid = 1; i_reg_write = 1; i_reg_dst = 1; i_uses_rs = 1;
            i_uses_rt = 1; i_rs = 5'd5; i_rt = 5'd6; i_rd = 5'd8;
            end_cycle();
        end

        // LW $0 followed by a reader of $0: no stall.
        load_instr(1'b1, 5'd0);
        begin_cycle();
        i_valid = 1; i_uses_rs = 1; i_rs = 5'd0; i_reg_write = 1;
        i_rt = 5'd3;
        end_cycle();

        // LW $7 followed by an instruction naming rt=7 but not reading it.
        load_instr(1'b1, 5'd7);
        begin_cycle();
        i_valid = 1; i_uses_rs = 1; i_rs = 5'd2; i_uses_rt = 0; i_rt = 5'd7;
        end_cycle();

        // Flush together with a hazard: one bubble, one count.
        load_instr(1'b1, 5'd9);
        begin_cycle();
        i_valid = 1; i_uses_rs = 1; i_rs = 5'd9; i_flush = 1;
        end_cycle();

        // Halt for 3 cycles with a live hazard and changing inputs, then release.
        load_instr(1'b1, 5'd4);
        for (int k = 0; k < 3; k++) begin
            begin_cycle();
            set_random();
            i_halt = 1; i_valid = 1; i_uses_rs = 1; i_rs = 5'd4;
            end_cycle();
        end
        begin_cycle();
        i_valid = 1; i_uses_rs = 1; i_rs = 5'd4; i_reg_write = 1;
        end_cycle();

        // Saturation: 20 flushes, counter must stop at 15.
        for (int k = 0; k < 20; k++) begin
            begin_cycle();
            set_random();
            i_halt = 0; i_flush = 1;
            end_cycle();
        end

        // JAL: destination 31 via reg_dst, branch class passes through.
        begin_cycle();
        i_valid = 1; i_reg_dst = 1; i_rd = 5'd31; i_rt = 5'd12;
        i_reg_write = 1; i_branch_type = 3'd2;
        end_cycle();

        // Asynchronous reset with nonzero EX contents.
        do_reset();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                begin_cycle();
                set_random();
                end_cycle();
            end
        end

        begin_cycle();
        end_cycle();
        @(negedge i_clk);
        check("scoreboard_drained", 256'(sb_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
